sel_arbiter: RTL



---
 rtl/sel_arb_pkg.sv | 23 ++
 rtl/sel_arb_pick.sv | 33 +++
 rtl/sel_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sel_arb_pkg.sv
// sel_arb_pkg: shared definitions for the 4:1 selector arbiter.
//   state_e  - arbiter FSM state (ST_IDLE, ST_GRANT)
//   SEL_W    - width of the selector select code (2)
//   NREQ     - number of requesters (4)
//   onehot4  - converts a select code into a one-hot grant vector
package sel_arb_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned NREQ  = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sel_arb_pick.sv
// sel_arb_pick: combinational winner finder.
// Searches req starting at index `start` and wrapping modulo 4; the first set bit wins.
//   req   in  [3:0]  request lines
//   start in  [1:0]  first index to consider (0 gives fixed lowest-index priority)
//   idx   out [1:0]  winning index (0 when no request)
//   any   out        at least one request is set
module sel_arb_pick
  import sel_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Walk from the furthest offset back to `start` so the last hit is the
  // closest one in search order.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = start + SEL_W'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_arbiter.sv
// sel_arbiter: control stage generating the 2-bit select code for the 4:1 byte selector.
// Grants one of four requesters at a time; a grant ends on done, on the owner dropping
// its request, or when the hold limit expires. A one-cycle idle gap always separates
// grants so sel never changes while valid is high.
//   clk      in        rising-edge clock
//   rst      in        asynchronous active-high reset
//   req      in  [3:0] request lines, bit i requests selector input i
//   done     in        owner releases the grant (ignored when idle)
//   sel      out [1:0] registered select code, held while idle
//   gnt      out [3:0] registered one-hot grant, zero when idle
//   valid    out       grant active; qualifies sel
//   expired  out       one-cycle pulse when a grant ends purely by hold-limit timeout
// Build option: define SEL_ARB_RR_EN for round-robin arbitration (search starts after
// the last winner); otherwise fixed priority, lowest index wins.
module sel_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned NREQ     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [1:0]      sel,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic            expired
);
  import sel_arb_pkg::*;

  localparam int unsigned CW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CntLast = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic            expired_q, expired_d;

  logic [1:0] start;
  logic [1:0] win;
  logic       any;
  logic       rel_norm;
  logic       timeout;

`ifdef SEL_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  assign start = ptr_q + 2'd1;
  assign ptr_d = (state_q == ST_IDLE && any) ? win : ptr_q;

  // Reset to 3 so index 0 is searched first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start = 2'd0;
`endif

  sel_arb_pick u_pick (
    .req   (req),
    .start (start),
    .idx   (win),
    .any   (any)
  );

  assign rel_norm = done | ~req[sel_q];
  assign timeout  = (HOLD_MAX != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    gnt_d     = '0;
    valid_d   = 1'b0;
    expired_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_GRANT;
          sel_d   = win;
          gnt_d   = onehot4(win);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (rel_norm || timeout) begin
          state_d   = ST_IDLE;
          // A coincident done/request-drop counts as a normal release.
          expired_d = timeout & ~rel_norm;
        end else begin
          gnt_d   = gnt_q;
          valid_d = 1'b1;
          // Saturate rather than wrap when the hold limit is disabled.
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign valid   = valid_q;
  assign expired = expired_q;

endmodule
